// File: rtl/itree_loader.sv
// Serial isolation-tree image loader: header byte, 32 payload bytes, optional XOR byte.
// The CHECK state is built only when ITREE_LOADER_CHECKSUM_EN is defined.
module itree_loader #(
  parameter logic [7:0] HDR_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CYC = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   byte_in,
  input  logic         byte_valid,
  output logic         byte_ready,
  input  logic         core_idle,
  output logic [255:0] itree_input,
  output logic         load_itree,
  output logic         tree_valid,
  output logic         frame_error,
  output logic [7:0]   err_count
);
  localparam int GW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYC - 1);

`ifdef ITREE_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, COMMIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, PAYLOAD, COMMIT} state_t;
`endif

  state_t         state_q;
  logic [255:0]   stage_q, itree_q;
  logic [4:0]     idx_q;
  logic [GW-1:0]  gap_q;
  logic           load_q, tv_q, ferr_q;
  logic [7:0]     err_q, err_d;
`ifdef ITREE_LOADER_CHECKSUM_EN
  logic [7:0]     xor_q;
`endif

  logic xfer;
  assign byte_ready = (state_q != COMMIT);
  assign xfer       = byte_valid && byte_ready;
  assign err_d      = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

  assign itree_input = itree_q;
  assign load_itree  = load_q;
  assign tree_valid  = tv_q;
  assign frame_error = ferr_q;
  assign err_count   = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      stage_q <= '0;
      itree_q <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      load_q  <= 1'b0;
      tv_q    <= 1'b0;
      ferr_q  <= 1'b0;
      err_q   <= '0;
`ifdef ITREE_LOADER_CHECKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      load_q <= 1'b0;
      ferr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (xfer && byte_in == HDR_BYTE) begin
            state_q <= PAYLOAD;
            idx_q   <= '0;
            gap_q   <= '0;
`ifdef ITREE_LOADER_CHECKSUM_EN
            xor_q   <= '0;
`endif
          end
        end
        PAYLOAD: begin
          // A transfer always wins over the gap limit, so the header value is plain data here
          if (xfer) begin
            stage_q[{idx_q, 3'b000} +: 8] <= byte_in;
            idx_q <= idx_q + 5'd1;
            gap_q <= '0;
`ifdef ITREE_LOADER_CHECKSUM_EN
            xor_q <= xor_q ^ byte_in;
            if (idx_q == 5'd31) state_q <= CHECK;
`else
            if (idx_q == 5'd31) state_q <= COMMIT;
`endif
          end else if (gap_q == GAP_LAST) begin
            state_q <= IDLE;
            ferr_q  <= 1'b1;
            err_q   <= err_d;
            gap_q   <= '0;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
`ifdef ITREE_LOADER_CHECKSUM_EN
        CHECK: begin
          if (xfer) begin
            gap_q <= '0;
            if (byte_in == xor_q) begin
              state_q <= COMMIT;
            end else begin
              state_q <= IDLE;
              ferr_q  <= 1'b1;
              err_q   <= err_d;
            end
          end else if (gap_q == GAP_LAST) begin
            state_q <= IDLE;
            ferr_q  <= 1'b1;
            err_q   <= err_d;
            gap_q   <= '0;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
`endif
        COMMIT: begin
          // Swap only while the core is between inferences; no timeout here
          if (core_idle) begin
            itree_q <= stage_q;
            load_q  <= 1'b1;
            tv_q    <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_itree_loader.sv
// Scoreboard bench for itree_loader: expected images and error counts are queued
// when a frame is driven and popped when load_itree / frame_error fire.
module tb_itree_loader;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   byte_in;
  logic         byte_valid;
  logic         byte_ready;
  logic         core_idle;
  logic [255:0] itree_input;
  logic         load_itree;
  logic         tree_valid;
  logic         frame_error;
  logic [7:0]   err_count;

  itree_loader #(.HDR_BYTE(8'hA5), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .core_idle(core_idle), .itree_input(itree_input),
    .load_itree(load_itree), .tree_valid(tree_valid), .frame_error(frame_error),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int exp_err = 0;
  logic [255:0] img_q[$];
  logic [7:0]   err_q[$];

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (load_itree) begin
      if (img_q.size() == 0) chk("spurious_load", load_itree, 1'b0);
      else begin
        chk("commit_img", itree_input, img_q.pop_front());
        chk("tree_valid", tree_valid, 1'b1);
      end
    end
    if (frame_error) begin
      if (err_q.size() == 0) chk("spurious_frame_error", frame_error, 1'b0);
      else chk("err_count_at_abort", err_count, err_q.pop_front());
    end
  end

  task automatic push_err();
    exp_err = (exp_err >= 255) ? 255 : exp_err + 1;
    err_q.push_back(8'(exp_err));
  endtask

  // Entered and left at a negedge; back-to-back calls transfer on consecutive edges.
  task automatic send(input logic [7:0] b);
    int w = 0;
    while (!byte_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!byte_ready) chk("ready_wait", byte_ready, 1'b1);
    byte_in = b;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [255:0] img, input bit bad_ck, input bit push,
                            input int gap_at, input int gap_len);
    logic [7:0] x = 8'h00;
    if (push) begin
`ifdef ITREE_LOADER_CHECKSUM_EN
      if (bad_ck) push_err(); else img_q.push_back(img);
`else
      img_q.push_back(img);
`endif
    end
    send(8'hA5);
    for (int k = 0; k < 32; k++) begin
      if (k == gap_at) repeat (gap_len) @(negedge clk);
      x = x ^ img[8*k +: 8];
      send(img[8*k +: 8]);
    end
`ifdef ITREE_LOADER_CHECKSUM_EN
    send(bad_ck ? (x ^ 8'h01) : x);
`endif
  endtask

  task automatic abort_timeout(input int nbytes);
    push_err();
    send(8'hA5);
    for (int k = 0; k < nbytes; k++) send(8'(k + 8'h40));
    repeat (TO + 4) @(negedge clk);
  endtask

  logic [255:0] img0, img1, img2, img3;
  int bad;

  initial begin
    for (int k = 0; k < 32; k++) begin
      img0[8*k +: 8] = 8'(k);
      img1[8*k +: 8] = 8'h11;
      img2[8*k +: 8] = 8'($urandom_range(0, 255));
      img3[8*k +: 8] = (k % 3 == 0) ? 8'hA5 : 8'(k * 7);
    end
    reset = 1'b1; byte_valid = 1'b0; byte_in = 8'h00; core_idle = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", byte_ready, 1'b1);
    chk("rst_itree", itree_input, '0);
    chk("rst_load", load_itree, 1'b0);
    chk("rst_tree_valid", tree_valid, 1'b0);
    chk("rst_frame_error", frame_error, 1'b0);
    chk("rst_err_count", err_count, 8'h00);
    reset = 1'b0;
    @(negedge clk);

    // reset in the middle of a frame: discarded, no load, no error
    send(8'hA5);
    for (int k = 0; k < 10; k++) send(img0[8*k +: 8]);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_ready", byte_ready, 1'b1);
    chk("midrst_err", err_count, 8'h00);
    chk("midrst_tree_valid", tree_valid, 1'b0);

    // junk in IDLE, then a good frame with minimum commit latency
    send(8'h3C);
    send(8'h00);
    send_frame(img0, 1'b0, 1'b1, -1, 0);
    chk("ready_in_commit", byte_ready, 1'b0);
    @(negedge clk);
    chk("min_latency_load", load_itree, 1'b1);
    @(negedge clk);
    chk("load_one_cycle", load_itree, 1'b0);
    chk("itree_lo", itree_input[7:0], 8'h00);
    chk("itree_hi", itree_input[255:248], 8'h1F);
    chk("junk_no_err", err_count, 8'h00);

`ifdef ITREE_LOADER_CHECKSUM_EN
    send_frame(img1, 1'b1, 1'b1, -1, 0);
    repeat (3) @(negedge clk);
    chk("ck_err_count", err_count, 8'h01);
    chk("ck_itree_kept", itree_input, img0);
`endif

    // commit held off by a busy core
    core_idle = 1'b0;
    send_frame(img2, 1'b0, 1'b0, -1, 0);
    bad = 0;
    repeat (50) begin
      if (byte_ready !== 1'b0 || load_itree !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("hold_ready_low", bad, 0);
    img_q.push_back(img2);
    core_idle = 1'b1;
    @(negedge clk);
    chk("hold_load", load_itree, 1'b1);
    chk("hold_ready_back", byte_ready, 1'b1);
    @(negedge clk);
    chk("hold_load_pulse", load_itree, 1'b0);

    // gap timeout aborts, next frame (header value as data) commits
    abort_timeout(5);
    chk("to_err_count", err_count, 8'(exp_err));
    chk("to_itree_kept", itree_input, img2);
    send_frame(img3, 1'b0, 1'b1, -1, 0);
    repeat (3) @(negedge clk);
    chk("after_to_itree", itree_input, img3);

    // one cycle short of the limit must not abort
    send_frame(img0, 1'b0, 1'b1, 6, TO - 1);
    repeat (3) @(negedge clk);
    chk("gap_below_limit", itree_input, img0);

    // saturation
    repeat (256) abort_timeout(1);
    chk("err_saturated", err_count, 8'hFF);

    repeat (5) @(negedge clk);
    chk("img_q_drained", img_q.size(), 0);
    chk("err_q_drained", err_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/itree_loader.md
ITREE_LOADER -- requirements
Module: itree_loader

Interface
REQ-001 Parameter HDR_BYTE, default 8'hA5, frame start marker.
REQ-002 Parameter TIMEOUT_CYC, default 1024, max idle cycles between bytes inside a frame.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 byte_in  input  8  serial tree-image byte.
REQ-006 byte_valid  input  1  byte_in valid; transfer occurs when byte_valid && byte_ready.
REQ-007 byte_ready  output  1  loader can accept a byte this cycle.
REQ-008 core_idle  input  1  isolation-tree core not mid-inference; tree swap permitted.
REQ-009 itree_input  output  256  committed tree image, held until next commit.
REQ-010 load_itree  output  1  one-cycle pulse, same cycle itree_input first shows new image.
REQ-011 tree_valid  output  1  at least one tree committed since reset.
REQ-012 frame_error  output  1  one-cycle pulse on aborted frame.
REQ-013 err_count  output  8  saturating count of aborted frames.

Function
REQ-014 States IDLE, PAYLOAD, CHECK, COMMIT; reset state IDLE.
REQ-015 IDLE: byte_ready=1; accepted byte == HDR_BYTE -> PAYLOAD, byte index=0, running XOR=0; other bytes dropped silently (no error).
REQ-016 PAYLOAD: byte_ready=1; accepted byte k (0..31) written to staging[8k+7:8k], XOR updated; after byte 31 -> CHECK (checksum on) or COMMIT (checksum off).
REQ-017 CHECK: byte_ready=1; accepted byte == running XOR -> COMMIT; mismatch -> IDLE, frame_error pulse, err_count+1.
REQ-018 COMMIT: byte_ready=0; on the first edge with core_idle=1, itree_input<=staging, load_itree=1 next cycle, tree_valid<=1, -> IDLE.
REQ-019 Minimum latency: final byte accepted at edge N, core_idle=1 -> load_itree high in cycle after edge N+1.
REQ-020 COMMIT waits indefinitely for core_idle; timeout does not apply in COMMIT.
REQ-021 Staging separate from itree_input; aborted or in-progress frames never alter itree_input.
REQ-022 Gap counter in PAYLOAD/CHECK: reset on each accepted byte; reaching TIMEOUT_CYC cycles without a transfer -> IDLE, frame_error pulse, err_count+1.
REQ-023 A byte equal to HDR_BYTE inside PAYLOAD/CHECK is data, not a restart.
REQ-024 err_count saturates at 8'hFF; timeout and checksum abort in same cycle impossible (distinct states), one increment per abort.
REQ-025 byte_ready is a function of state only (no combinational path from byte_valid).

Reset
REQ-026 While reset=1 at posedge: state=IDLE, itree_input=0, staging=0, load_itree=0, tree_valid=0, frame_error=0, err_count=0, index/XOR/gap counter=0.
REQ-027 Reset mid-frame or in COMMIT discards the frame with no load_itree and no err_count change; byte_ready=1 from first cycle after reset.

Configuration
REQ-028 Macro ITREE_LOADER_CHECKSUM_EN defined: CHECK state present, frame = header + 32 payload + 1 XOR byte.
REQ-029 Macro undefined: CHECK state and XOR logic absent, frame = header + 32 payload, PAYLOAD goes directly to COMMIT; timeout and err_count still active.

Verification
REQ-030 Checksum on, core_idle=1: A5, bytes 00..1F, XOR byte 00 -> load_itree one cycle, itree_input[7:0]=00, [255:248]=1F, tree_valid=1.
REQ-031 Checksum on: A5, 32x 8'h11, checksum 8'h01 (expected 00) -> frame_error pulse, err_count=1, itree_input unchanged, no load_itree.
REQ-032 Valid frame with core_idle=0 for 50 cycles after last byte -> byte_ready=0 throughout, load_itree exactly 1 cycle after core_idle rises, then byte_ready=1.
REQ-033 TIMEOUT_CYC=16: A5 + 5 bytes, then byte_valid=0 for 16 cycles -> frame_error pulse, err_count+1, state IDLE; following full frame commits normally.
REQ-034 Bytes 3C, 00 in IDLE then valid frame -> no error, single commit; reset asserted at payload byte 10 -> no load_itree, err_count unchanged.
REQ-035 Checksum off build: A5 + 32 bytes -> load_itree with no trailing byte; 256 consecutive aborts -> err_count holds FF.
